// File: rtl/bp_be_pkg.sv
// Shared back-end types for the dcache LR/SC reservation tracker.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_locked,
    e_open
  } bp_be_lrsc_state_e;

endpackage

// File: rtl/bp_be_dcache_lrsc_tracker_if.sv
// Committed-op, snoop and result signals between the dcache decoder side and the LR/SC tracker.
interface bp_be_dcache_lrsc_tracker_if #(
  parameter int paddr_width_p        = 40,
  parameter int block_offset_width_p = 6
);

  logic                                         v_i;
  logic                                         lr_op_i;
  logic                                         sc_op_i;
  logic                                         l2_op_i;
  logic [paddr_width_p-1:0]                     paddr_i;
  logic                                         clear_i;
  logic                                         snoop_v_i;
  logic [paddr_width_p-1:0]                     snoop_paddr_i;
  logic                                         snoop_yumi_o;
  logic                                         sc_v_o;
  logic                                         sc_success_o;
  logic                                         resv_v_o;
  logic [paddr_width_p-block_offset_width_p-1:0] resv_block_o;

  modport master (
    output v_i, lr_op_i, sc_op_i, l2_op_i, paddr_i, clear_i, snoop_v_i, snoop_paddr_i,
    input  snoop_yumi_o, sc_v_o, sc_success_o, resv_v_o, resv_block_o
  );

  modport slave (
    input  v_i, lr_op_i, sc_op_i, l2_op_i, paddr_i, clear_i, snoop_v_i, snoop_paddr_i,
    output snoop_yumi_o, sc_v_o, sc_success_o, resv_v_o, resv_block_o
  );

endinterface

// File: rtl/bp_be_lrsc_timer.sv
// Loadable down-counter measuring how long a fresh reservation refuses matching snoops.
module bp_be_lrsc_timer #(
  parameter int lr_timeout_p = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int cnt_width_lp = (lr_timeout_p > 1) ? $clog2(lr_timeout_p) : 1;
  localparam logic [cnt_width_lp-1:0] reload_lp = cnt_width_lp'(lr_timeout_p - 1);

  logic [cnt_width_lp-1:0] cnt;

  // NOTE: reset is synchronous, so it lives inside the clocked block and is tested first.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= reload_lp;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - cnt_width_lp'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bp_be_dcache_lrsc_tracker.sv
// Single block-granular LR/SC reservation with registered SC results and post-LR snoop hold-off.
module bp_be_dcache_lrsc_tracker
  import bp_be_pkg::*;
#(
  parameter int paddr_width_p        = 40,
  parameter int block_offset_width_p = 6,
  parameter int lr_timeout_p         = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bp_be_dcache_lrsc_tracker_if.slave  bus
);

  localparam int block_width_lp = paddr_width_p - block_offset_width_p;

  bp_be_lrsc_state_e          state, state_n;
  logic [block_width_lp-1:0]  resv_block;
  logic                       sc_v, sc_success, resv_v;

  logic [block_width_lp-1:0]  op_block, snoop_block;
  logic                       lr, sc, op_match, snoop_match, snoop_kill, sc_success_n;
  logic                       timer_load, timer_dec, timer_zero;
  logic                       unused_offset_bits;

  assign op_block    = bus.paddr_i[paddr_width_p-1:block_offset_width_p];
  assign snoop_block = bus.snoop_paddr_i[paddr_width_p-1:block_offset_width_p];
  assign unused_offset_bits = ^{bus.paddr_i[block_offset_width_p-1:0],
                                bus.snoop_paddr_i[block_offset_width_p-1:0]};

  assign lr          = bus.v_i & bus.lr_op_i & ~bus.l2_op_i;
  assign sc          = bus.v_i & bus.sc_op_i & ~bus.l2_op_i;
  assign op_match    = (op_block == resv_block);
  assign snoop_match = (snoop_block == resv_block);

  // A matching snoop is only refused while the fresh-reservation window is running.
  assign bus.snoop_yumi_o = bus.snoop_v_i & ~((state == e_locked) & snoop_match);
  assign snoop_kill       = bus.snoop_yumi_o & snoop_match & (state != e_idle);

  assign sc_success_n = sc & (state != e_idle) & op_match & ~bus.clear_i & ~snoop_kill;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n    = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    unique case (state)
      e_idle: begin
        if (lr && !bus.clear_i) begin
          state_n    = e_locked;
          timer_load = 1'b1;
        end
      end
      e_locked: begin
        if (bus.clear_i || sc) begin
          state_n = e_idle;
        end else if (lr) begin
          timer_load = 1'b1;
        end else if (timer_zero) begin
          state_n = e_open;
        end else begin
          timer_dec = 1'b1;
        end
      end
      e_open: begin
        if (bus.clear_i || snoop_kill || sc) begin
          state_n = e_idle;
        end else if (lr) begin
          state_n    = e_locked;
          timer_load = 1'b1;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state      <= e_idle;
      resv_block <= '0;
      sc_v       <= 1'b0;
      sc_success <= 1'b0;
      resv_v     <= 1'b0;
    end else begin
      state      <= state_n;
      if (timer_load) resv_block <= op_block;
      sc_v       <= sc;
      sc_success <= sc_success_n;
      resv_v     <= (state_n != e_idle);
    end
  end

  bp_be_lrsc_timer #(
    .lr_timeout_p(lr_timeout_p)
  ) timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load      (timer_load),
    .dec       (timer_dec),
    .zero      (timer_zero)
  );

  assign bus.sc_v_o       = sc_v;
  assign bus.sc_success_o = sc_success;
  assign bus.resv_v_o     = resv_v;
  assign bus.resv_block_o = resv_block;

  lr_sc_exclusive: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(lr && sc));

endmodule
